// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// instruction-fetch blocking while MEM owns the shared SRAM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; branch, load-use and mem-busy evaluated here
// FLUSH    | remaining cycles of a taken-branch flush of IF/ID and ID/EXE
// LU_STALL | one cycle after a load-use bubble; hazard detection suppressed
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             pci_clk,
  input  logic             pci_rst,
  input  logic [3:0]       pci_id_rreg1,
  input  logic [3:0]       pci_id_rreg2,
  input  logic [3:0]       pci_ex_wreg_addr,
  input  logic [1:0]       pci_ex_rwe,
  input  logic             pci_ex_branch_taken,
  input  logic             pci_mem_busy,
  input  logic             pci_cnt_clr,
  output logic             pco_pc_en,
  output logic             pco_ifid_en,
  output logic             pco_ifid_flush,
  output logic             pco_idexe_en,
  output logic [1:0]       pco_state,
  output logic [CNT_W-1:0] pco_stall_cnt,
  output logic [CNT_W-1:0] pco_flush_cnt
);

  localparam logic [3:0] REG_INVALID = 4'hF;
  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RWE_IDLE  = 2'd0,
    RWE_READ  = 2'd1,
    RWE_WRITE = 2'd2
  } rwe_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_LU_STALL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;
  logic             lu_hazard;
  logic             src1_hit, src2_hit;

  always_comb begin
    src1_hit  = (pci_id_rreg1 != REG_INVALID) && (pci_id_rreg1 == pci_ex_wreg_addr);
    src2_hit  = (pci_id_rreg2 != REG_INVALID) && (pci_id_rreg2 == pci_ex_wreg_addr);
    lu_hazard = (pci_ex_rwe == RWE_READ) && (pci_ex_wreg_addr != REG_INVALID)
                && (src1_hit || src2_hit);
  end

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    pco_pc_en      = 1'b1;
    pco_ifid_en    = 1'b1;
    pco_ifid_flush = 1'b0;
    pco_idexe_en   = 1'b1;
    case (state_q)
      ST_RUN: begin
        if (pci_ex_branch_taken) begin
          pco_ifid_flush = 1'b1;
          pco_idexe_en   = 1'b0;
          flush_inc      = 1'b1;
          fcnt_d         = FLUSH_LOAD;
          state_d        = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        end else if (lu_hazard) begin
          pco_pc_en    = 1'b0;
          pco_ifid_en  = 1'b0;
          pco_idexe_en = 1'b0;
          stall_inc    = 1'b1;
          state_d      = ST_LU_STALL;
        end else if (pci_mem_busy) begin
          // No fetch possible: hold PC and feed a NOP into IF/ID.
          pco_pc_en      = 1'b0;
          pco_ifid_flush = 1'b1;
        end
      end
      ST_FLUSH: begin
        pco_pc_en      = !pci_mem_busy;
        pco_ifid_flush = 1'b1;
        pco_idexe_en   = 1'b0;
        if (fcnt_q <= 3'd1) begin
          fcnt_d  = 3'd0;
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      ST_LU_STALL: begin
        pco_pc_en      = !pci_mem_busy;
        pco_ifid_flush = pci_mem_busy;
        state_d        = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Reset forces a safe pipeline posture without waiting for a clock.
    if (!pci_rst) begin
      pco_pc_en      = 1'b0;
      pco_ifid_en    = 1'b0;
      pco_ifid_flush = 1'b1;
      pco_idexe_en   = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pci_cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pci_clk or negedge pci_rst) begin
    if (!pci_rst) begin
      state_q     <= ST_RUN;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pco_state     = state_q;
  assign pco_stall_cnt = stall_cnt_q;
  assign pco_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each directed vector pushes its expected
// control outputs, state and counters; a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic             pci_clk = 1'b0;
  logic             pci_rst = 1'b0;
  logic [3:0]       pci_id_rreg1 = 4'd1;
  logic [3:0]       pci_id_rreg2 = 4'd2;
  logic [3:0]       pci_ex_wreg_addr = 4'd5;
  logic [1:0]       pci_ex_rwe = 2'd0;
  logic             pci_ex_branch_taken = 1'b0;
  logic             pci_mem_busy = 1'b0;
  logic             pci_cnt_clr = 1'b0;
  logic             pco_pc_en, pco_ifid_en, pco_ifid_flush, pco_idexe_en;
  logic [1:0]       pco_state;
  logic [CNT_W-1:0] pco_stall_cnt, pco_flush_cnt;

  pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .pci_clk(pci_clk), .pci_rst(pci_rst),
    .pci_id_rreg1(pci_id_rreg1), .pci_id_rreg2(pci_id_rreg2),
    .pci_ex_wreg_addr(pci_ex_wreg_addr), .pci_ex_rwe(pci_ex_rwe),
    .pci_ex_branch_taken(pci_ex_branch_taken), .pci_mem_busy(pci_mem_busy),
    .pci_cnt_clr(pci_cnt_clr),
    .pco_pc_en(pco_pc_en), .pco_ifid_en(pco_ifid_en),
    .pco_ifid_flush(pco_ifid_flush), .pco_idexe_en(pco_idexe_en),
    .pco_state(pco_state), .pco_stall_cnt(pco_stall_cnt),
    .pco_flush_cnt(pco_flush_cnt)
  );

  always #5 pci_clk = ~pci_clk;

  // {pc_en, ifid_en, ifid_flush, idexe_en}
  localparam logic [3:0] O_RUN  = 4'b1101;
  localparam logic [3:0] O_LU   = 4'b0000;
  localparam logic [3:0] O_BUSY = 4'b0111;
  localparam logic [3:0] O_BR   = 4'b1110;
  localparam logic [3:0] O_FLB  = 4'b0110;
  localparam logic [3:0] O_RST  = 4'b0010;
  localparam logic [1:0] S_RUN = 2'd0, S_FL = 2'd1, S_LUS = 2'd2;

  logic [13:0] exp_q[$];
  int          id_q[$];
  int          tests = 0;
  int          failed = 0;
  int          vec_id = 0;

  task automatic step(input logic rst, input logic [3:0] r1, input logic [3:0] r2,
                      input logic [3:0] wa, input logic [1:0] rwe, input logic br,
                      input logic busy, input logic clr, input logic [3:0] eo,
                      input logic [1:0] es, input logic [3:0] esc, input logic [3:0] efc);
    @(posedge pci_clk);
    #1;
    pci_rst = rst; pci_id_rreg1 = r1; pci_id_rreg2 = r2;
    pci_ex_wreg_addr = wa; pci_ex_rwe = rwe; pci_ex_branch_taken = br;
    pci_mem_busy = busy; pci_cnt_clr = clr;
    exp_q.push_back({eo, es, esc, efc});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic idle(input logic [3:0] eo, input logic [1:0] es,
                      input logic [3:0] esc, input logic [3:0] efc);
    step(1'b1, 4'd1, 4'd2, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0, eo, es, esc, efc);
  endtask

  always @(negedge pci_clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] exp_v, act_v;
      int vid;
      exp_v = exp_q.pop_front();
      vid   = id_q.pop_front();
      act_v = {pco_pc_en, pco_ifid_en, pco_ifid_flush, pco_idexe_en,
               pco_state, pco_stall_cnt, pco_flush_cnt};
      tests++;
      if (act_v !== exp_v) begin
        failed++;
        $display("FAIL vec%0d {pc,ifid,flush,idexe,state,stall,flush_cnt}: got %b_%h_%h_%h required %b_%h_%h_%h",
                 vid, act_v[13:10], act_v[9:8], act_v[7:4], act_v[3:0],
                 exp_v[13:10], exp_v[9:8], exp_v[7:4], exp_v[3:0]);
      end
    end
  end

  initial begin
    // Reset posture, then release
    step(1'b0, 4'd1, 4'd2, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0, O_RST, S_RUN, 4'd0, 4'd0);
    idle(O_RUN, S_RUN, 4'd0, 4'd0);
    // Load-use via rreg2, hazard inputs held through LU_STALL are ignored
    step(1'b1, 4'd1, 4'd3, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0, O_LU, S_RUN, 4'd0, 4'd0);
    step(1'b1, 4'd1, 4'd3, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0, O_RUN, S_LUS, 4'd1, 4'd0);
    idle(O_RUN, S_RUN, 4'd1, 4'd0);
    // No hazard: invalid dest, invalid sources, write access
    step(1'b1, 4'hF, 4'd4, 4'hF, 2'd1, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN, 4'd1, 4'd0);
    step(1'b1, 4'hF, 4'hF, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN, 4'd1, 4'd0);
    step(1'b1, 4'd1, 4'd3, 4'd3, 2'd2, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN, 4'd1, 4'd0);
    // Load-use via rreg1, mem busy during LU_STALL
    step(1'b1, 4'd7, 4'hF, 4'd7, 2'd1, 1'b0, 1'b0, 1'b0, O_LU, S_RUN, 4'd1, 4'd0);
    step(1'b1, 4'd1, 4'd2, 4'd5, 2'd0, 1'b0, 1'b1, 1'b0, O_BUSY, S_LUS, 4'd2, 4'd0);
    idle(O_RUN, S_RUN, 4'd2, 4'd0);
    // Mem busy for three cycles in RUN
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'd1, 4'd2, 4'd5, 2'd0, 1'b0, 1'b1, 1'b0, O_BUSY, S_RUN, 4'd2, 4'd0);
    idle(O_RUN, S_RUN, 4'd2, 4'd0);
    // Taken branch, two flush cycles
    step(1'b1, 4'd1, 4'd2, 4'd5, 2'd0, 1'b1, 1'b0, 1'b0, O_BR, S_RUN, 4'd2, 4'd0);
    idle(O_BR, S_FL, 4'd2, 4'd1);
    idle(O_RUN, S_RUN, 4'd2, 4'd1);
    // Branch, then FLUSH with busy + branch + LU ignored except pc_en
    step(1'b1, 4'd1, 4'd2, 4'd5, 2'd0, 1'b1, 1'b0, 1'b0, O_BR, S_RUN, 4'd2, 4'd1);
    step(1'b1, 4'd3, 4'd2, 4'd3, 2'd1, 1'b1, 1'b1, 1'b0, O_FLB, S_FL, 4'd2, 4'd2);
    idle(O_RUN, S_RUN, 4'd2, 4'd2);
    // Branch beats LU and mem busy
    step(1'b1, 4'd3, 4'd2, 4'd3, 2'd1, 1'b1, 1'b1, 1'b0, O_BR, S_RUN, 4'd2, 4'd2);
    step(1'b1, 4'd3, 4'd2, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0, O_BR, S_FL, 4'd2, 4'd3);
    idle(O_RUN, S_RUN, 4'd2, 4'd3);
    // Clear, then 17 load-use events to saturate the 4-bit counter
    step(1'b1, 4'd1, 4'd2, 4'd5, 2'd0, 1'b0, 1'b0, 1'b1, O_RUN, S_RUN, 4'd2, 4'd3);
    idle(O_RUN, S_RUN, 4'd0, 4'd0);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 4'd3, 4'd4, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0, O_LU, S_RUN,
           (i > 15) ? 4'd15 : 4'(i), 4'd0);
      idle(O_RUN, S_LUS, (i + 1 > 15) ? 4'd15 : 4'(i + 1), 4'd0);
    end
    idle(O_RUN, S_RUN, 4'd15, 4'd0);
    // Clear wins over a simultaneous LU increment
    step(1'b1, 4'd3, 4'd4, 4'd3, 2'd1, 1'b0, 1'b0, 1'b1, O_LU, S_RUN, 4'd15, 4'd0);
    idle(O_RUN, S_LUS, 4'd0, 4'd0);
    idle(O_RUN, S_RUN, 4'd0, 4'd0);
    // Reset dropped during FLUSH
    step(1'b1, 4'd1, 4'd2, 4'd5, 2'd0, 1'b1, 1'b0, 1'b0, O_BR, S_RUN, 4'd0, 4'd0);
    step(1'b0, 4'd1, 4'd2, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0, O_RST, S_RUN, 4'd0, 4'd0);
    idle(O_RUN, S_RUN, 4'd0, 4'd0);
    idle(O_RUN, S_RUN, 4'd0, 4'd0);

    repeat (2) @(negedge pci_clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, total cycles IF/ID and ID/EXE are flushed on a taken branch (legal range 1..4).
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 pci_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 pci_rst  in  1  reset; asynchronous, active-low.
REQ-005 pci_id_rreg1  in  4  first source register of the instruction in ID; REG_INVALID means unused.
REQ-006 pci_id_rreg2  in  4  second source register of the instruction in ID; REG_INVALID means unused.
REQ-007 pci_ex_wreg_addr  in  4  destination register of the instruction in EXE (ID/EXE register output).
REQ-008 pci_ex_rwe  in  2  memory access type of the instruction in EXE (RWE_IDLE / RWE_READ / RWE_WRITE).
REQ-009 pci_ex_branch_taken  in  1  the instruction in EXE resolved a taken branch this cycle.
REQ-010 pci_mem_busy  in  1  MEM stage owns the shared SRAM this cycle, so no instruction fetch is possible.
REQ-011 pci_cnt_clr  in  1  synchronous clear of both statistics counters.
REQ-012 pco_pc_en  out  1  PC register load enable.
REQ-013 pco_ifid_en  out  1  IF/ID load enable; 0 holds IF/ID.
REQ-014 pco_ifid_flush  out  1  IF/ID loads a NOP; takes effect only when pco_ifid_en=1.
REQ-015 pco_idexe_en  out  1  ID/EXE enable; 0 loads a bubble (REG_INVALID, RWE_IDLE, branch=0).
REQ-016 pco_state  out  2  current FSM state: RUN=0, FLUSH=1, LU_STALL=2.
REQ-017 pco_stall_cnt  out  CNT_W  number of load-use bubbles inserted, saturating.
REQ-018 pco_flush_cnt  out  CNT_W  number of taken-branch flush events, saturating.

Function
REQ-019 Control outputs are combinational from the current state and current inputs; the state, flush counter and statistics counters are registered.
REQ-020 Load-use hazard (LU) is true when pci_ex_rwe=RWE_READ, pci_ex_wreg_addr!=REG_INVALID, and the address equals either pci_id_rreg1 or pci_id_rreg2, ignoring any source equal to REG_INVALID.
REQ-021 In RUN, conditions are taken in priority order: pci_ex_branch_taken, then LU, then pci_mem_busy, then none.
REQ-022 RUN with branch taken: pc_en=1, ifid_en=1, ifid_flush=1, idexe_en=0, regardless of pci_mem_busy.
REQ-023 The same branch cycle increments pco_flush_cnt, loads the flush counter with FLUSH_CYCLES-1, and sets next state to FLUSH, or to RUN if FLUSH_CYCLES=1.
REQ-024 RUN with LU: pc_en=0, ifid_en=0, ifid_flush=0, idexe_en=0, regardless of pci_mem_busy.
REQ-025 The same LU cycle increments pco_stall_cnt and sets next state to LU_STALL.
REQ-026 RUN with pci_mem_busy only: pc_en=0, ifid_en=1, ifid_flush=1, idexe_en=1; state stays RUN.
REQ-027 RUN with no condition: pc_en=1, ifid_en=1, ifid_flush=0, idexe_en=1.
REQ-028 FLUSH outputs: pc_en=!pci_mem_busy, ifid_en=1, ifid_flush=1, idexe_en=0; pci_ex_branch_taken and LU are ignored.
REQ-029 FLUSH decrements the flush counter each cycle and moves to RUN in the cycle the counter reads 1.
REQ-030 LU_STALL lasts exactly one cycle, then returns to RUN; LU and branch detection are suppressed in it.
REQ-031 LU_STALL outputs: pc_en=!pci_mem_busy, ifid_en=1, ifid_flush=pci_mem_busy, idexe_en=1.
REQ-032 Statistics counters saturate at all-ones and do not wrap.
REQ-033 pci_cnt_clr has priority over increments in the same cycle; both counters read 0 on the next cycle.

Reset
REQ-034 While pci_rst=0: state=RUN, flush counter=0, both statistics counters=0.
REQ-035 While pci_rst=0, outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idexe_en=0, independent of the clock.
REQ-036 Reset asserted mid-FLUSH or mid-LU_STALL aborts the operation; the first cycle after release behaves as RUN.

Verification
REQ-037 Apply ex_rwe=RWE_READ, ex_wreg_addr=3, id_rreg2=3, with no branch and no mem_busy -> one cycle pc_en=0/ifid_en=0/idexe_en=0, state=LU_STALL, next cycle RUN outputs, stall_cnt=1.
REQ-038 Apply the same as REQ-037 but ex_wreg_addr=REG_INVALID, or id_rreg1/id_rreg2 = REG_INVALID -> no stall, stall_cnt unchanged.
REQ-039 Pulse branch_taken for 1 cycle with FLUSH_CYCLES=2 -> 2 consecutive cycles of ifid_flush=1/idexe_en=0, pc_en=1 in the first cycle, then RUN; flush_cnt=1.
REQ-040 Assert branch_taken together with LU and mem_busy in RUN -> branch outputs win; no stall_cnt increment.
REQ-041 Assert mem_busy for 3 cycles in RUN -> pc_en=0, ifid_flush=1, idexe_en=1 for 3 cycles; state stays RUN.
REQ-042 With CNT_W=4, apply 17 LU events, then cnt_clr together with an LU -> stall_cnt reads 15 after the 17 events, then 0; drop pci_rst during FLUSH -> outputs take the reset values immediately, and the cycle after release is RUN.
